// File: rtl/sram_rw_sequencer.sv
// SRAM request-to-macro sequencer: precharge, wordline, sense and recovery
// phases driven as registered Moore controls, one request at a time.
module sram_rw_sequencer #(
  parameter int numRows   = 128,
  parameter int numCols   = 32,
  parameter int pchCycles = 2,
  parameter int wlCycles  = 2,
  parameter int saCycles  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rq_valid_i,
  input  logic                         rq_wr_i,
  input  logic [$clog2(numRows)-1:0]   addr_i,
  input  logic [numCols-1:0]           wr_data_i,
  output logic                         rq_ready_o,
  output logic                         rd_valid_o,
  output logic [numCols-1:0]           rd_data_o,
  output logic [numRows-1:0]           WL,
  output logic                         PCH,
  output logic                         WRITE,
  output logic [numCols-1:0]           WR_DATA,
  output logic [numCols-1:0]           CSEL,
  output logic                         SAEN,
  input  logic [numCols-1:0]           SA_OUT
);

  localparam int AW   = $clog2(numRows);
  localparam int MX0  = (pchCycles > wlCycles) ? pchCycles : wlCycles;
  localparam int MAXC = (MX0 > saCycles) ? MX0 : saCycles;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE, PRECH, ACT, SENSE, RECOV
  } state_t;

  state_t            state_q, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [AW-1:0]     addr_q;
  logic              wr_q;
  logic [numCols-1:0] data_q;
  logic              last;

  logic [numRows-1:0] wl_dec, wl_n;
  logic               pch_n, write_n, saen_n, rd_valid_n;
  logic [numCols-1:0] wr_data_n, csel_n;

  assign rq_ready_o = (state_q == IDLE) & ~rst;
  assign last       = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (rq_valid_i && state_q == IDLE) begin
        addr_q <= addr_i;
        wr_q   <= rq_wr_i;
        data_q <= wr_data_i;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = last ? '0 : cnt_q - CW'(1);
    unique case (state_q)
      IDLE:    if (rq_valid_i) state_n = PRECH;
      PRECH:   if (last) state_n = ACT;
      ACT:     if (last) state_n = wr_q ? RECOV : SENSE;
      SENSE:   if (last) state_n = RECOV;
      RECOV:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // phase counter reloads on every state entry
    if (state_n != state_q) begin
      unique case (state_n)
        PRECH:   cnt_n = CW'(pchCycles - 1);
        ACT:     cnt_n = CW'(wlCycles - 1);
        SENSE:   cnt_n = CW'(saCycles - 1);
        default: cnt_n = '0;
      endcase
    end
  end

  // out-of-range rows decode to an all-zero wordline
  always_comb begin
    for (int i = 0; i < numRows; i++) begin
      wl_dec[i] = (addr_q == AW'(i));
    end
  end

  always_comb begin
    wl_n       = '0;
    pch_n      = 1'b0;
    write_n    = 1'b0;
    wr_data_n  = '0;
    csel_n     = '0;
    saen_n     = 1'b0;
    rd_valid_n = 1'b0;
    unique case (state_n)
      PRECH: pch_n = 1'b1;
      ACT: begin
        wl_n      = wl_dec;
        csel_n    = '1;
        write_n   = wr_q;
        wr_data_n = wr_q ? data_q : '0;
      end
      SENSE: begin
        wl_n   = wl_dec;
        csel_n = '1;
        saen_n = 1'b1;
      end
      RECOV:   rd_valid_n = ~wr_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WL         <= '0;
      PCH        <= 1'b0;
      WRITE      <= 1'b0;
      WR_DATA    <= '0;
      CSEL       <= '0;
      SAEN       <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      WL         <= wl_n;
      PCH        <= pch_n;
      WRITE      <= write_n;
      WR_DATA    <= wr_data_n;
      CSEL       <= csel_n;
      SAEN       <= saen_n;
      rd_valid_o <= rd_valid_n;
      if (state_q == SENSE && state_n == RECOV) begin
        rd_data_o <= SA_OUT & {numCols{|wl_dec}};
      end
    end
  end

endmodule

// File: tb/tb_sram_rw_sequencer.sv
// Bench for sram_rw_sequencer: default instance plus an overridden one
// (pch=3, wl=1, sa=2, 100 rows) checked against a phase-arithmetic model.
module tb_sram_rw_sequencer;

  typedef logic [228:0] obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq_valid, rq_wr, sel;
  logic [6:0]  addr;
  logic [31:0] wr_data, sa_out;

  logic         a_ready, a_rdv, a_pch, a_write, a_saen;
  logic [31:0]  a_rdd, a_wrd, a_csel;
  logic [127:0] a_wl;
  logic         b_ready, b_rdv, b_pch, b_write, b_saen;
  logic [31:0]  b_rdd, b_wrd, b_csel;
  logic [99:0]  b_wl;

  logic         o_ready, o_rdv, o_pch, o_write, o_saen;
  logic [31:0]  o_rdd, o_wrd, o_csel;
  logic [127:0] o_wl;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd [2];
  bit          sa_pin;
  logic [31:0] sa_val;

  always #5 clk = ~clk;

  sram_rw_sequencer dut_a (
    .clk(clk), .rst(rst), .rq_valid_i(rq_valid & ~sel), .rq_wr_i(rq_wr),
    .addr_i(addr), .wr_data_i(wr_data), .rq_ready_o(a_ready),
    .rd_valid_o(a_rdv), .rd_data_o(a_rdd), .WL(a_wl), .PCH(a_pch),
    .WRITE(a_write), .WR_DATA(a_wrd), .CSEL(a_csel), .SAEN(a_saen),
    .SA_OUT(sa_out)
  );

  sram_rw_sequencer #(
    .numRows(100), .numCols(32), .pchCycles(3), .wlCycles(1), .saCycles(2)
  ) dut_b (
    .clk(clk), .rst(rst), .rq_valid_i(rq_valid & sel), .rq_wr_i(rq_wr),
    .addr_i(addr), .wr_data_i(wr_data), .rq_ready_o(b_ready),
    .rd_valid_o(b_rdv), .rd_data_o(b_rdd), .WL(b_wl), .PCH(b_pch),
    .WRITE(b_write), .WR_DATA(b_wrd), .CSEL(b_csel), .SAEN(b_saen),
    .SA_OUT(sa_out)
  );

  assign o_ready = sel ? b_ready : a_ready;
  assign o_rdv   = sel ? b_rdv   : a_rdv;
  assign o_pch   = sel ? b_pch   : a_pch;
  assign o_write = sel ? b_write : a_write;
  assign o_saen  = sel ? b_saen  : a_saen;
  assign o_rdd   = sel ? b_rdd   : a_rdd;
  assign o_wrd   = sel ? b_wrd   : a_wrd;
  assign o_csel  = sel ? b_csel  : a_csel;
  assign o_wl    = sel ? {28'b0, b_wl} : a_wl;

  function automatic obs_t mk(input bit pch, input logic [127:0] wl,
                              input bit wrt, input logic [31:0] wrd,
                              input logic [31:0] csel, input bit saen,
                              input bit rdv, input bit rdy,
                              input logic [31:0] rdd);
    return {pch, wl, wrt, wrd, csel, saen, rdv, rdy, rdd};
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t got;
    got = {o_pch, o_wl, o_write, o_wrd, o_csel, o_saen, o_rdv, o_ready, o_rdd};
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, mk(0, '0, 0, '0, '0, 0, 0, 1, exp_rd[sel]));
      @(posedge clk); #1;
    end
  endtask

  // Precondition: just after a rising edge with the selected DUT idle.
  task automatic do_req(input bit wr, input logic [6:0] a,
                        input logic [31:0] d, input bit hold,
                        input int rst_at, input string tag);
    int p, w, s, nr, total, lsense;
    bit inr, pre, act, sen, rec, aborted;
    logic [127:0] wl_e;
    obs_t e;
    p  = sel ? 3 : 2;
    w  = sel ? 1 : 2;
    s  = sel ? 2 : 1;
    nr = sel ? 100 : 128;
    rq_valid = 1'b1; rq_wr = wr; addr = a; wr_data = d;
    @(negedge clk);
    check({tag, " accept"}, mk(0, '0, 0, '0, '0, 0, 0, 1, exp_rd[sel]));
    @(posedge clk); #1;
    if (!hold) rq_valid = 1'b0;
    rq_wr = 1'($urandom); addr = 7'($urandom); wr_data = $urandom;
    total  = p + w + (wr ? 0 : s) + 1;
    lsense = wr ? -1 : p + w + s;
    inr  = int'(a) < nr;
    wl_e = inr ? (128'b1 << a) : '0;
    for (int k = 1; k <= total; k++) begin
      sa_out = (sa_pin && k == lsense) ? sa_val : $urandom;
      if (k == rst_at) rst = 1'b1;
      aborted = (rst_at != 0) && (k > rst_at);
      @(negedge clk);
      pre = k <= p;
      act = (k > p) && (k <= p + w);
      sen = !wr && (k > p + w) && (k <= p + w + s);
      rec = k == total;
      if (aborted)
        e = mk(0, '0, 0, '0, '0, 0, 0, 0, 32'h0);
      else
        e = mk(pre, (act | sen) ? wl_e : '0, act & wr,
               (act & wr) ? d : 32'h0, (act | sen) ? 32'hFFFF_FFFF : 32'h0,
               sen, rec & !wr, 0, exp_rd[sel]);
      check($sformatf("%s c%0d", tag, k), e);
      if (k == lsense && !aborted && k != rst_at)
        exp_rd[sel] = inr ? sa_out : 32'h0;
      if (k == rst_at) begin
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
      end
      @(posedge clk); #1;
      if (aborted) begin
        rst = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; rq_valid = 1'b0; rq_wr = 1'b0; sel = 1'b0;
    addr = '0; wr_data = '0; sa_out = '0;
    sa_pin = 1'b0; sa_val = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("reset", mk(0, '0, 0, '0, '0, 0, 0, 0, 32'h0));
    end
    rst = 1'b0;
    @(posedge clk); #1;
    idle_check(2, "post_reset");

    do_req(1, 7'd5, 32'hA5A5_0F0F, 0, 0, "wr5");
    idle_check(1, "wr5_idle");

    sa_pin = 1'b1; sa_val = 32'hDEAD_BEEF;
    do_req(0, 7'd127, 32'h0, 0, 0, "rd127");
    sa_pin = 1'b0;
    idle_check(3, "rd127_hold");
    checks++;
    assert (o_rdd === 32'hDEAD_BEEF) else begin
      failures++;
      $error("FAIL rd127_data got=%h exp=%h", o_rdd, 32'hDEAD_BEEF);
    end

    do_req(1, 7'd9, 32'h1234_5678, 1, 0, "b2b_wr");
    do_req(0, 7'd9, 32'h0, 0, 0, "b2b_rd");
    idle_check(2, "b2b_idle");

    do_req(0, 7'd40, 32'h0, 0, 3, "abort");
    idle_check(1, "abort_idle");
    do_req(0, 7'd41, 32'h0, 0, 0, "after_abort");
    idle_check(1, "after_abort_idle");

    for (int n = 0; n < 20; n++) begin
      bit hold;
      hold = (n != 19) && 1'($urandom);
      do_req(1'($urandom), 7'($urandom), $urandom, hold, 0,
             $sformatf("rnd%0d", n));
    end
    idle_check(1, "rnd_idle");

    sel = 1'b1;
    idle_check(1, "ovr_idle");
    do_req(0, 7'd17, 32'h0, 0, 0, "ovr_rd");
    do_req(1, 7'd99, 32'hCAFE_F00D, 0, 0, "ovr_wr99");
    do_req(0, 7'd110, 32'h0, 0, 0, "ovr_oor");
    for (int n = 0; n < 8; n++) begin
      do_req(1'($urandom), 7'($urandom), $urandom, 1'(n != 7 && $urandom % 2),
             0, $sformatf("ovr_rnd%0d", n));
    end
    idle_check(2, "ovr_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
